// File: rtl/stuff_frame_tx.sv
// ---------------------------------------------------------------------------
// stuff_frame_tx
//
// Serial frame transmitter with bit stuffing. A parallel word accepted over a
// valid/ready handshake is sent as a start marker of MARK_LEN ones, one 0
// separator, and then the payload MSB first. Inside the payload the
// transmitter never lets MARK_LEN identical bits appear in a row. When the
// run of equal bits on the line reaches MARK_LEN-1 and the next payload bit
// would extend it, an inverted stuff bit is sent first. A run detector on the
// line can therefore only fire on the marker or on idle zeros.
//
// Parameters:
//   W        payload width in bits
//   MARK_LEN marker length in ones (legal range 3..8)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   data_in  in   [W-1:0] payload word, sampled on the handshake edge
//   valid    in   data_in valid
//   ready    out  idle and able to accept a word (registered)
//   out      out  serial line (registered)
//   stuffed  out  high while out carries a stuff bit (registered)
//   done     out  one-cycle pulse while out carries the last payload bit
// ---------------------------------------------------------------------------
module stuff_frame_tx #(
    parameter int W        = 8,
    parameter int MARK_LEN = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] data_in,
    input  logic         valid,
    output logic         ready,
    output logic         out,
    output logic         stuffed,
    output logic         done
);

    localparam int BW = $clog2(W + 1);
    localparam int MW = $clog2(MARK_LEN + 1);
    localparam int RW = $clog2(MARK_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SEP,
        DATA
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [MW-1:0]  mark_cnt_q, mark_cnt_d;
    logic [RW-1:0]  run_q, run_d;
    logic           last_q, last_d;
    logic           out_q, out_d;
    logic           ready_q, ready_d;
    logic           stuffed_q, stuffed_d;
    logic           done_q, done_d;
    logic           next_bit;
    logic           need_stuff;

    assign ready   = ready_q;
    assign out     = out_q;
    assign stuffed = stuffed_q;
    assign done    = done_q;

    // State and every output live in one register bank so that the line,
    // the handshake and the status flags all change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            mark_cnt_q <= '0;
            run_q      <= '0;
            last_q     <= 1'b0;
            out_q      <= 1'b0;
            ready_q    <= 1'b1;
            stuffed_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            mark_cnt_q <= mark_cnt_d;
            run_q      <= run_d;
            last_q     <= last_d;
            out_q      <= out_d;
            ready_q    <= ready_d;
            stuffed_q  <= stuffed_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic. The registered outputs always describe the bit that
    // is currently on the line, so each branch decides what the line carries
    // during the following cycle. The run tracker (last, run) describes the
    // trailing run of equal bits already on the line. It is seeded by the
    // separator, so the 0 separator counts toward a run of leading zeros.
    // A stuff bit does not consume the payload bit. The next cycle therefore
    // retries the same bit, which can no longer extend the run.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        mark_cnt_d = mark_cnt_q;
        run_d      = run_q;
        last_d     = last_q;
        out_d      = 1'b0;
        ready_d    = 1'b0;
        stuffed_d  = 1'b0;
        done_d     = 1'b0;
        next_bit   = shift_q[W-1];
        need_stuff = (run_q == RW'(MARK_LEN - 1)) && (next_bit == last_q);

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (valid && ready_q) begin
                    shift_d    = data_in;
                    bit_cnt_d  = '0;
                    mark_cnt_d = MW'(1);
                    state_d    = MARK;
                    out_d      = 1'b1;
                    ready_d    = 1'b0;
                end
            end

            MARK: begin
                if (mark_cnt_q == MW'(MARK_LEN)) begin
                    state_d = SEP;
                    out_d   = 1'b0;
                    last_d  = 1'b0;
                    run_d   = RW'(1);
                end else begin
                    out_d      = 1'b1;
                    mark_cnt_d = mark_cnt_q + MW'(1);
                end
            end

            SEP, DATA: begin
                if (state_q == DATA && done_q) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    run_d   = '0;
                    last_d  = 1'b0;
                end else if (need_stuff) begin
                    state_d   = DATA;
                    out_d     = ~last_q;
                    stuffed_d = 1'b1;
                    last_d    = ~last_q;
                    run_d     = RW'(1);
                end else begin
                    state_d   = DATA;
                    out_d     = next_bit;
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    done_d    = (bit_cnt_q == BW'(W - 1));
                    if (next_bit == last_q) begin
                        run_d = run_q + RW'(1);
                    end else begin
                        run_d  = RW'(1);
                        last_d = next_bit;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_stuff_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_stuff_frame_tx
//
// Self-checking bench for stuff_frame_tx (W=8, MARK_LEN=4). A table of known
// frames is replayed first. Hand-written sequences then cover back-to-back
// frames, a reset in mid-frame and valid pulses while busy. Finally, random
// words are checked against a stream model. The model builds the expected
// line contents bit by bit. It scans the trailing run of the bits it has
// already produced to decide where stuff bits go.
// ---------------------------------------------------------------------------
module tb_stuff_frame_tx;

    localparam int W        = 8;
    localparam int MARK_LEN = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] data_in;
    logic         valid;
    logic         ready;
    logic         out;
    logic         stuffed;
    logic         done;

    int checks;
    int errors;

    bit exp_out_q[$];
    bit exp_stf_q[$];

    typedef struct packed {
        logic [7:0]  word;
        logic [4:0]  len;
        logic [23:0] bits;
        logic [23:0] stf;
        logic        noise;
    } vec_t;

    vec_t vecs[5];

    stuff_frame_tx #(
        .W        (W),
        .MARK_LEN (MARK_LEN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .out     (out),
        .stuffed (stuffed),
        .done    (done)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to one time unit after the next rising edge. Outputs are
    // sampled there and inputs are changed there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] word, input logic v);
        data_in = word;
        valid   = v;
    endtask

    // One comparison covering the four outputs together.
    task automatic checkOutput(input string name, input int idx,
                               input bit e_out, input bit e_stf,
                               input bit e_done, input bit e_rdy);
        checks++;
        if ({out, stuffed, done, ready} !== {e_out, e_stf, e_done, e_rdy}) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got out=%b stuffed=%b done=%b ready=%b, want out=%b stuffed=%b done=%b ready=%b",
                     name, idx, out, stuffed, done, ready, e_out, e_stf, e_done, e_rdy);
        end
    endtask

    // Expected line contents for one frame, built from the framing rules:
    // marker ones, a 0 separator, then the payload MSB first. A stuff bit is
    // inserted whenever the trailing run on the line already holds
    // MARK_LEN-1 copies of the next payload bit.
    task automatic buildModel(input logic [W-1:0] word);
        int n;
        int j;
        bit b;
        exp_out_q.delete();
        exp_stf_q.delete();
        for (int i = 0; i < MARK_LEN; i++) begin
            exp_out_q.push_back(1'b1);
            exp_stf_q.push_back(1'b0);
        end
        exp_out_q.push_back(1'b0);
        exp_stf_q.push_back(1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            b = word[i];
            n = 0;
            j = exp_out_q.size() - 1;
            while (j >= 0 && exp_out_q[j] == b) begin
                n++;
                j--;
            end
            if (n == MARK_LEN - 1) begin
                exp_out_q.push_back(~b);
                exp_stf_q.push_back(1'b1);
            end
            exp_out_q.push_back(b);
            exp_stf_q.push_back(1'b0);
        end
    endtask

    // Load the expected queues from a table entry. The stream is MSB first.
    task automatic loadVector(input vec_t v);
        int len;
        len = int'(v.len);
        exp_out_q.delete();
        exp_stf_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_out_q.push_back(v.bits[len - 1 - i]);
            exp_stf_q.push_back(v.stf[len - 1 - i]);
        end
    endtask

    // Check a whole frame. The caller must already have the first marker bit
    // on the line. The task then checks the idle cycle that follows. With
    // noise set, valid and data_in toggle randomly while the frame runs.
    // Noise is cleared again before the frame ends.
    task automatic checkFrame(input string name, input bit noise);
        int len;
        len = exp_out_q.size();
        for (int i = 0; i < len; i++) begin
            checkOutput(name, i, exp_out_q[i], exp_stf_q[i], (i == len - 1), 1'b0);
            if (noise) begin
                if (i < len - 1) applyStimulus(W'($urandom), 1'($urandom));
                else             applyStimulus(W'($urandom), 1'b0);
            end
            step();
        end
        checkOutput({name, "-idle"}, len, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Expected streams worked out by hand from the framing rules.
        vecs[0] = '{8'hA5, 5'd13, 24'b1111_0_10100101,         24'b0,                          1'b0};
        vecs[1] = '{8'hFF, 5'd15, 24'b1111_0_111_0_111_0_11,   24'b0000_0_000_1_000_1_00,      1'b0};
        vecs[2] = '{8'h00, 5'd15, 24'b1111_0_00_1_000_1_000,   24'b0000_0_00_1_000_1_000,      1'b1};
        vecs[3] = '{8'h3C, 5'd14, 24'b1111_0_00_111_0_1_00,    24'b0000_0_00_000_1_0_00,       1'b0};
        vecs[4] = '{8'h0F, 5'd15, 24'b1111_0_00_1_00_111_0_1,  24'b0000_0_00_1_00_000_1_0,     1'b1};

        // Reset is held with valid high. The word must not be accepted.
        reset = 1'b1;
        applyStimulus(8'hA5, 1'b1);
        step();
        step();
        checkOutput("reset", 0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        applyStimulus(8'h00, 1'b0);
        step();
        checkOutput("post-reset", 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Table-driven frames.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(vecs[k].word, 1'b1);
            step();
            applyStimulus(8'h00, 1'b0);
            loadVector(vecs[k]);
            checkFrame($sformatf("vec%0d", k), vecs[k].noise);
        end

        // Back-to-back: valid stays high and data_in changes in mid-frame.
        // Exactly one idle bit separates the two frames.
        applyStimulus(8'hA5, 1'b1);
        step();
        applyStimulus(8'h3C, 1'b1);
        loadVector(vecs[0]);
        checkFrame("b2b-A5", 1'b0);
        step();
        applyStimulus(8'hFF, 1'b0);
        loadVector(vecs[3]);
        checkFrame("b2b-3C", 1'b0);

        // Reset one cycle into the payload of 8'hFF, with valid high.
        applyStimulus(8'hFF, 1'b1);
        step();
        applyStimulus(8'hFF, 1'b0);
        for (int i = 0; i < MARK_LEN + 1; i++) step();
        checkOutput("pre-reset-payload", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(8'h5A, 1'b1);
        step();
        reset = 1'b0;
        applyStimulus(8'h00, 1'b0);
        checkOutput("midframe-reset", 0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("midframe-reset-idle", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hA5, 1'b1);
        step();
        applyStimulus(8'h00, 1'b0);
        loadVector(vecs[0]);
        checkFrame("after-reset-A5", 1'b0);

        // Random words against the stream model. The gaps are random and
        // valid is noisy while a frame runs.
        for (int r = 0; r < 40; r++) begin
            logic [W-1:0] w;
            int gap;
            w   = W'($urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step();
                checkOutput("rand-gap", g, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            applyStimulus(w, 1'b1);
            step();
            applyStimulus(8'h00, 1'b0);
            buildModel(w);
            checkFrame($sformatf("rand%0d-%02h", r, w), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
